// File: rtl/scan_test_ctrl_if.sv
// Link between the scan test controller and the 4-bit scan-chain up-counter:
// increment strobe, scan enable, serial scan-in and the chain's scan-out.
interface scan_test_ctrl_if;
    logic bIncrement;
    logic bScanEn;
    logic bScanIn;
    logic bScanOut;

    modport master (
        output bIncrement,
        output bScanEn,
        output bScanIn,
        input  bScanOut
    );

    modport slave (
        input  bIncrement,
        input  bScanEn,
        input  bScanIn,
        output bScanOut
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// Button debouncer/increment strobe and load/unload scan test sequencer
// for the scan-chain up-counter.
module scan_test_ctrl #(
    parameter int unsigned CHAIN_LEN       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 BrdClk,
    input  logic                 aReset_n,
    input  logic                 aButton,
    input  logic                 aStart,
    input  logic [CHAIN_LEN-1:0] aPattern,
    scan_test_ctrl_if.master     chain,
    output logic                 bBusy,
    output logic                 bDone,
    output logic                 bPass,
    output logic [CHAIN_LEN-1:0] bCapture
);

    localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, CHECK} state_t;

    // Asserts asynchronously, releases two BrdClk edges after aReset_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge BrdClk or negedge aReset_n) begin
        if (!aReset_n) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [1:0] btn_sync_q;
    logic [1:0] start_sync_q;
    logic       start_prev_q;
    logic       start_edge;

    always_ff @(posedge BrdClk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q   <= '0;
            start_sync_q <= '0;
            start_prev_q <= 1'b0;
        end else begin
            btn_sync_q   <= {btn_sync_q[0], aButton};
            start_sync_q <= {start_sync_q[0], aStart};
            start_prev_q <= start_sync_q[1];
        end
    end

    assign start_edge = start_sync_q[1] & ~start_prev_q;

    logic            db_lvl_q, db_lvl_d;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_rise;

    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        if (btn_sync_q[1] != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) db_lvl_d = btn_sync_q[1];
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge BrdClk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            db_cnt_q  <= db_cnt_d;
        end
    end

    assign db_rise = db_lvl_q & ~db_prev_q;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CHAIN_LEN-1:0] pat_q;
    logic [CHAIN_LEN-1:0] sh_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CHAIN_LEN-1:0] capture_q;
    logic                 inc_q, scan_en_q, scan_in_q, busy_q, done_q, pass_q;

    // Outputs are registered one state ahead: sh_q holds the pattern already
    // advanced by the MSB that leaves on the start edge.
    always_ff @(posedge BrdClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            sh_q      <= '0;
            cap_q     <= '0;
            capture_q <= '0;
            inc_q     <= 1'b0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            inc_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    scan_en_q <= 1'b0;
                    scan_in_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (start_edge) begin
                        pat_q     <= aPattern;
                        sh_q      <= {aPattern[CHAIN_LEN-2:0], 1'b0};
                        scan_in_q <= aPattern[CHAIN_LEN-1];
                        scan_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= LOAD;
                    end else if (db_rise) begin
                        inc_q <= 1'b1;
                    end
                end
                LOAD: begin
                    sh_q <= {sh_q[CHAIN_LEN-2:0], 1'b0};
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        scan_in_q <= 1'b0;
                        state_q   <= UNLOAD;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        scan_in_q <= sh_q[CHAIN_LEN-1];
                    end
                end
                UNLOAD: begin
                    cap_q <= {cap_q[CHAIN_LEN-2:0], chain.bScanOut};
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        scan_en_q <= 1'b0;
                        state_q   <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    capture_q <= cap_q;
                    pass_q    <= (cap_q == pat_q);
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign chain.bIncrement = inc_q;
    assign chain.bScanEn    = scan_en_q;
    assign chain.bScanIn    = scan_in_q;
    assign bBusy            = busy_q;
    assign bDone            = done_q;
    assign bPass            = pass_q;
    assign bCapture         = capture_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Scoreboard bench for scan_test_ctrl with a behavioural 4-bit scan-chain
// up-counter (optional stuck-at-0 on bit 2) hanging off the scan link.
module tb_scan_test_ctrl;

    localparam int CL = 4;
    localparam int DC = 16;

    typedef struct {
        int       start;
        logic [3:0] cap;
        logic     pass;
    } test_t;

    logic       BrdClk;
    logic       aReset_n;
    logic       aButton;
    logic       aStart;
    logic [3:0] aPattern;
    logic       bBusy, bDone, bPass;
    logic [3:0] bCapture;

    logic [3:0] chain_q;
    logic       stuck;
    int         cyc;
    int         exp_count;
    int         n_checks;
    int         n_errors;

    int    inc_q[$];
    logic  bit_q[$];
    test_t test_q[$];

    scan_test_ctrl_if sif();

    scan_test_ctrl #(
        .CHAIN_LEN(CL),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .BrdClk  (BrdClk),
        .aReset_n(aReset_n),
        .aButton (aButton),
        .aStart  (aStart),
        .aPattern(aPattern),
        .chain   (sif.master),
        .bBusy   (bBusy),
        .bDone   (bDone),
        .bPass   (bPass),
        .bCapture(bCapture)
    );

    initial begin
        BrdClk = 1'b0;
        forever #5 BrdClk = ~BrdClk;
    end

    initial cyc = 0;
    always @(posedge BrdClk) cyc <= cyc + 1;

    // Downstream counter: shift when scan-enabled, otherwise count strobes.
    always @(posedge BrdClk or negedge aReset_n) begin
        logic [3:0] nxt;
        if (!aReset_n) begin
            chain_q <= 4'd0;
        end else begin
            if (sif.bScanEn)         nxt = {chain_q[2:0], sif.bScanIn};
            else if (sif.bIncrement) nxt = chain_q + 4'd1;
            else                     nxt = chain_q;
            if (stuck) nxt[2] = 1'b0;
            chain_q <= nxt;
        end
    end

    assign sif.bScanOut = chain_q[3];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge BrdClk);
        #2;
    endtask

    task automatic run_scan(input logic [3:0] p, input logic [3:0] exp_cap, input int hold);
        test_t t;
        aPattern = p;
        t.start  = cyc;
        t.cap    = exp_cap;
        t.pass   = (exp_cap == p);
        test_q.push_back(t);
        for (int i = CL - 1; i >= 0; i--) bit_q.push_back(p[i]);
        for (int i = 0; i < CL; i++) bit_q.push_back(1'b0);
        aStart = 1'b1;
        cycles(hold);
        aStart = 1'b0;
    endtask

    logic  en_prev, busy_prev;
    int    en_len, busy_len;
    test_t done_t;

    always @(negedge BrdClk) begin
        if (!aReset_n) begin
            en_prev   = 1'b0;
            busy_prev = 1'b0;
            en_len    = 0;
            busy_len  = 0;
        end else begin
            if (sif.bIncrement) begin
                if (inc_q.size() == 0) chk("inc_unexpected", sif.bIncrement, 0);
                else                   chk("inc_cycle", cyc, inc_q.pop_front());
            end
            if (sif.bScanEn && !en_prev) begin
                if (test_q.size() == 0) chk("start_unexpected", sif.bScanEn, 0);
                else                    chk("start_latency", cyc, test_q[0].start + 3);
            end
            if (sif.bScanEn) begin
                en_len++;
                if (bit_q.size() == 0) chk("scanin_unexpected", sif.bScanEn, 0);
                else                   chk("scan_in", sif.bScanIn, bit_q.pop_front());
            end else if (en_prev) begin
                chk("scanen_len", en_len, 2 * CL);
                en_len = 0;
            end
            if (bBusy) begin
                busy_len++;
            end else if (busy_prev) begin
                chk("busy_len", busy_len, 2 * CL + 1);
                busy_len = 0;
            end
            if (bDone) begin
                if (test_q.size() == 0) begin
                    chk("done_unexpected", bDone, 0);
                end else begin
                    done_t = test_q.pop_front();
                    chk("done_cycle", cyc, done_t.start + 2 * CL + 4);
                    chk("capture", bCapture, done_t.cap);
                    chk("pass", bPass, done_t.pass);
                    chk("chain_after", chain_q, 0);
                end
            end
            en_prev   = sif.bScanEn;
            busy_prev = bBusy;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_count = 0;
        stuck     = 1'b0;
        aButton   = 1'b0;
        aStart    = 1'b0;
        aPattern  = 4'd0;
        aReset_n  = 1'b1;
        #1 aReset_n = 1'b0;
        #1 chk("reset_outputs", {sif.bIncrement, sif.bScanEn, sif.bScanIn, bBusy, bDone, bPass, bCapture}, 0);
        cycles(3);
        aReset_n = 1'b1;
        cycles(5);

        // Clean press: one strobe DC+3 edges after the rise, none on release.
        aButton = 1'b1;
        inc_q.push_back(cyc + DC + 3);
        exp_count++;
        cycles(40);
        chk("count_after_press", chain_q, exp_count);
        aButton = 1'b0;
        cycles(30);

        // Bounce: toggling every 5 cycles never qualifies; the final steady rise does.
        for (int i = 0; i < 12; i++) begin
            aButton = ~aButton;
            cycles(5);
        end
        aButton = 1'b1;
        inc_q.push_back(cyc + DC + 3);
        exp_count++;
        cycles(40);
        chk("count_after_bounce", chain_q, exp_count);
        aButton = 1'b0;
        cycles(30);

        // Passing scan test.
        run_scan(4'b1011, 4'b1011, 3);
        cycles(25);

        // Reset in the middle of LOAD: everything clears, no result is reported.
        run_scan(4'b0110, 4'b0110, 5);
        chk("midload_scanen", sif.bScanEn, 1);
        aReset_n = 1'b0;
        #1 chk("midload_reset_outputs",
               {sif.bIncrement, sif.bScanEn, sif.bScanIn, bBusy, bDone, bPass, bCapture}, 0);
        test_q.delete();
        bit_q.delete();
        cycles(3);
        aReset_n = 1'b1;
        cycles(20);

        // Failing scan test: chain bit 2 stuck at 0.
        stuck = 1'b1;
        run_scan(4'b0100, 4'b0000, 3);
        cycles(25);
        stuck = 1'b0;
        cycles(5);

        // Lockout: a button edge and a second start edge inside the test are ignored.
        aButton = 1'b1;
        cycles(11);
        run_scan(4'b0110, 4'b0110, 3);
        cycles(2);
        aStart = 1'b1;
        cycles(25);
        aStart  = 1'b0;
        aButton = 1'b0;
        cycles(30);

        // Start edge and debounced button edge in the same IDLE cycle: start wins.
        aButton = 1'b1;
        cycles(16);
        run_scan(4'b1001, 4'b1001, 3);
        cycles(25);
        aButton = 1'b0;
        cycles(30);

        chk("inc_queue_empty", inc_q.size(), 0);
        chk("bit_queue_empty", bit_q.size(), 0);
        chk("test_queue_empty", test_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Control stage directly upstream of the 4-bit scan-chain up-counter. It turns a raw board button into clean single-cycle increment strobes. On request, it runs a load/unload scan burst through the counter's output flip-flops: it drives the scan enable and scan-in, captures the scan-out stream, and reports pass/fail against the pattern it loaded.

## Interface
- CHAIN_LEN, 4: scan chain length in flip-flops; must match the counter width.
- DEBOUNCE_CYCLES, 16: consecutive stable BrdClk cycles required before a button level is accepted; minimum 2.

- BrdClk  in  1  board clock; every register uses its rising edge.
- aReset_n  in  1  asynchronous, active-low reset; deassertion is synchronised internally to BrdClk.
- aButton  in  1  raw, bouncy, asynchronous increment button (active high).
- aStart  in  1  asynchronous scan-test request (active high, level).
- aPattern  in  CHAIN_LEN  pattern to load; quasi-static, sampled on the start edge.
- bScanOut  in  1  scan-out from the counter chain (its last flip-flop).
- bIncrement  out  1  one-cycle increment strobe to the counter.
- bScanEn  out  1  scan enable to the counter.
- bScanIn  out  1  serial scan data to the counter.
- bBusy  out  1  high while a scan test is running.
- bDone  out  1  one-cycle pulse when a test completes.
- bPass  out  1  result of the last completed test; held until the next completion.
- bCapture  out  CHAIN_LEN  word captured during the last unload.

## Operation
- aButton and aStart each pass through a 2-flop synchroniser.
- **Debounce:**
  - A counter runs while the synchronised button differs from the debounced level and clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- **Increment:**
  - A rising edge of the debounced level produces bIncrement = 1 for exactly one cycle, provided the FSM is in IDLE.
  - Presses whose debounced edge falls in any other state are dropped. Debouncing itself continues during a test.
- **Start:** a rising edge of the synchronised aStart (sync2 high, previous value low) triggers a test. The edge is ignored unless the FSM is in IDLE. Holding aStart high triggers exactly one test.
- **FSM states:** IDLE, LOAD, UNLOAD, CHECK. A bit counter cnt runs 0..CHAIN_LEN-1.
  - IDLE: bScanEn=0, bScanIn=0, bBusy=0. On a start edge: latch pattern P=aPattern, set cnt=0, go to LOAD.
  - LOAD: bScanEn=1, bBusy=1, bScanIn=P[CHAIN_LEN-1-cnt] (MSB first). When cnt reaches CHAIN_LEN-1, clear cnt and go to UNLOAD.
  - UNLOAD: bScanEn=1, bBusy=1, bScanIn=0.
    - Each edge shifts the capture register left: capture <= {capture[CHAIN_LEN-2:0], bScanOut}, using the pre-shift chain value.
    - When cnt reaches CHAIN_LEN-1, go to CHECK.
  - CHECK: bScanEn=0, bBusy=1. On this edge: bCapture <= capture, bPass <= (capture == P), bDone pulses for one cycle. Then return to IDLE.
- After a test the counter holds 0, because zeros were shifted in during UNLOAD. Software must not assume the pre-test count survives.
- **Reset values:**
  - bIncrement, bScanEn, bScanIn, bBusy, bDone, bPass: 0.
  - bCapture: 0.
  - Debounced level 0; FSM in IDLE.

## Timing
- All outputs are registered. Nothing combinational runs from input to output.
- **Start latency:** bScanEn rises on the 3rd BrdClk edge after aStart rises (2 synchroniser edges + 1 FSM edge).
- **Test length:** bScanEn stays high for exactly 2*CHAIN_LEN cycles (8 at default). bDone pulses the cycle after bScanEn falls. bBusy stays high for 2*CHAIN_LEN+1 cycles.
- **Increment latency:** bIncrement pulses DEBOUNCE_CYCLES+3 edges after a clean aButton rise (default 19).
- A bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no strobe.
- A start edge and a debounced button edge in the same IDLE cycle: the start wins and the increment is dropped.
- Reset asserted mid-test: all outputs clear immediately (asynchronously) and the FSM returns to IDLE. bPass and bCapture also clear, and no bDone is produced.

## Test plan
- **Reset:** assert aReset_n=0 mid-LOAD -> all outputs 0 immediately. After release, FSM is in IDLE with no spurious bIncrement or bDone.
- **Clean press:** aButton held high 40 cycles -> exactly one bIncrement pulse at edge 19. Counter bCount goes 0 -> 1. Release produces no pulse.
- **Bounce:** aButton toggling every 5 cycles for 60 cycles, then steady high -> exactly one bIncrement, 19 edges after the last rise.
- **Scan pass:** aPattern=4'b1011, pulse aStart -> bScanEn high for 8 cycles, bScanIn sequence 1,0,1,1,0,0,0,0. bDone pulses; bCapture=4'b1011, bPass=1; counter reads 0.
- **Scan fail:** force the counter chain bit 2 stuck at 0, aPattern=4'b0100 -> bCapture=4'b0000, bPass=0.
- **Busy lockout:** second aStart edge and a button press during a test -> ignored. Exactly one bDone, no bIncrement.
